// File: rtl/bit_serial_pkg.sv
// Shared definitions for the bit-serial link: receiver state encoding, idle line
// level and counter-width helper used by both transmit and receive sides.
package bit_serial_pkg;

    localparam logic LINE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        BRK
    } rx_state_t;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle level.
module bit_sync
    import bit_serial_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= LINE_IDLE;
            o_q    <= LINE_IDLE;
        end else begin
            r_meta <= i_d;
            o_q    <= r_meta;
        end
    end

endmodule

// File: rtl/bit_serial_rx.sv
// Serial receiver: start detect, mid-bit sampling, LSB-first deserialise, valid/ready out.
// Optional even parity bit enabled by defining BIT_SERIAL_RX_PARITY_EN.
module bit_serial_rx
    import bit_serial_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned HOLD_DEPTH   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_frm_err,
    output logic              o_ovr
);

    localparam int unsigned CNT_W  = cnt_w(CLKS_PER_BIT);
    localparam int unsigned BITS_W = cnt_w(DATA_W);

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BITS_W-1:0] BITS_LAST = BITS_W'(DATA_W - 1);

    if (HOLD_DEPTH != 1) begin : g_bad_hold
        $error("bit_serial_rx: HOLD_DEPTH must be 1");
    end
    if ((CLKS_PER_BIT < 4) || (CLKS_PER_BIT % 2 != 0)) begin : g_bad_cpb
        $error("bit_serial_rx: CLKS_PER_BIT must be even and >= 4");
    end
    if ((DATA_W < 1) || (DATA_W > 16)) begin : g_bad_dw
        $error("bit_serial_rx: DATA_W must be 1..16");
    end

    logic              w_s;
    rx_state_t         r_state, w_state_nx;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
    logic [BITS_W-1:0] r_bits, w_bits_nx;
    logic [DATA_W-1:0] r_shift, w_shift_nx;
    logic [DATA_W:0]   w_cat;
    logic              w_full;
    logic              w_deliver;
    logic              w_frm_err;
    logic              r_deliver;
`ifdef BIT_SERIAL_RX_PARITY_EN
    logic              r_par_err, w_par_err_nx;
`endif

    bit_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (i),
        .o_q   (w_s)
    );

    assign w_cat  = {w_s, r_shift};
    assign w_full = (r_cnt == CNT_FULL);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + 1'b1;
        w_bits_nx  = r_bits;
        w_shift_nx = r_shift;
        w_deliver  = 1'b0;
        w_frm_err  = 1'b0;
`ifdef BIT_SERIAL_RX_PARITY_EN
        w_par_err_nx = r_par_err;
`endif
        case (r_state)
            IDLE: begin
                w_cnt_nx = '0;
                if (w_s != LINE_IDLE) begin
                    w_state_nx = START;
                    w_bits_nx  = '0;
`ifdef BIT_SERIAL_RX_PARITY_EN
                    w_par_err_nx = 1'b0;
`endif
                end
            end
            START: begin
                if (r_cnt == CNT_HALF) begin
                    w_cnt_nx   = '0;
                    w_state_nx = (w_s != LINE_IDLE) ? DATA : IDLE;
                end
            end
            DATA: begin
                if (w_full) begin
                    w_cnt_nx   = '0;
                    w_shift_nx = w_cat[DATA_W:1];
                    w_bits_nx  = r_bits + 1'b1;
                    if (r_bits == BITS_LAST) begin
`ifdef BIT_SERIAL_RX_PARITY_EN
                        w_state_nx = PAR;
`else
                        w_state_nx = STOP;
`endif
                    end
                end
            end
`ifdef BIT_SERIAL_RX_PARITY_EN
            PAR: begin
                if (w_full) begin
                    w_cnt_nx     = '0;
                    w_par_err_nx = ^w_cat;
                    w_state_nx   = STOP;
                end
            end
`endif
            STOP: begin
                if (w_full) begin
                    w_cnt_nx = '0;
                    if (w_s == LINE_IDLE) begin
                        w_state_nx = IDLE;
`ifdef BIT_SERIAL_RX_PARITY_EN
                        w_frm_err = r_par_err;
                        w_deliver = !r_par_err;
`else
                        w_deliver = 1'b1;
`endif
                    end else begin
                        w_frm_err  = 1'b1;
                        w_state_nx = BRK;
                    end
                end
            end
            BRK: begin
                w_cnt_nx = '0;
                if (w_s == LINE_IDLE) w_state_nx = IDLE;
            end
            default: begin
                w_cnt_nx   = '0;
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bits  <= '0;
            r_shift <= '0;
`ifdef BIT_SERIAL_RX_PARITY_EN
            r_par_err <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_bits  <= w_bits_nx;
            r_shift <= w_shift_nx;
`ifdef BIT_SERIAL_RX_PARITY_EN
            r_par_err <= w_par_err_nx;
`endif
        end
    end

    // r_shift is untouched in IDLE, so it is still the finished word one cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_deliver <= 1'b0;
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_frm_err <= 1'b0;
            o_ovr     <= 1'b0;
        end else begin
            r_deliver <= w_deliver;
            o_frm_err <= w_frm_err;
            o_ovr     <= 1'b0;
            if (r_deliver) begin
                if (o_valid && !i_ready) begin
                    o_ovr <= 1'b1;
                end else begin
                    o_data  <= r_shift;
                    o_valid <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bit_serial_rx.sv
// Scoreboard bench for bit_serial_rx; define BIT_SERIAL_RX_PARITY_EN to cover parity.
module tb_bit_serial_rx;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef BIT_SERIAL_RX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    localparam int LAT = 2 + CPB / 2 + (DW + 1 + NPAR) * CPB + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          i_ready;
    logic          o_frm_err;
    logic          o_ovr;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int t0    = 0;
    int rise_cyc = 0;
    int n_vcyc = 0;
    int n_frm  = 0;
    int n_ovr  = 0;
    logic prev_v = 1'b0;
    logic [DW-1:0] exp_q[$];

    bit_serial_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .HOLD_DEPTH(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i         (i),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_frm_err (o_frm_err),
        .o_ovr     (o_ovr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid) n_vcyc++;
            if (o_valid && !prev_v) rise_cyc = cyc;
            if (o_frm_err) n_frm++;
            if (o_ovr) n_ovr++;
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) chk("extra_word_valid", {31'b0, o_valid}, 32'd0);
                else                   chk("word", {24'b0, o_data}, {24'b0, exp_q.pop_front()});
            end
        end
        prev_v = o_valid;
    end

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #2;
            i = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic stop_b,
                              input logic bad_par, input int cut);
        logic [15:0] fr;
        int nb;
        fr = '0;
        for (int k = 0; k < DW; k++) fr[k+1] = d[k];
        nb = DW + 1;
`ifdef BIT_SERIAL_RX_PARITY_EN
        fr[nb] = (^d) ^ bad_par;
        nb++;
`else
        if (bad_par) fr[nb] = 1'b0;
`endif
        fr[nb] = stop_b;
        nb++;
        for (int c = 0; c < nb * CPB; c++) begin
            if (cut != 0 && c >= cut) break;
            @(posedge clk); #2;
            if (c == 0) t0 = cyc + 1;
            i = fr[c / CPB];
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i = 1'b1; i_ready = 1'b1; rst_n = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("rst_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_frm", {31'b0, o_frm_err}, 32'd0);
        chk("rst_ovr", {31'b0, o_ovr}, 32'd0);
        chk("rst_data", {24'b0, o_data}, 32'd0);
        rst_n = 1'b1;
        n_vcyc = 0; n_frm = 0; n_ovr = 0;
        idle_cycles(50);
        chk("idle_valid_cycles", n_vcyc, 0);
        chk("idle_frm", n_frm, 0);
        chk("idle_ovr", n_ovr, 0);

        // single frame, latency and single-cycle valid
        n_vcyc = 0;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0, 0);
        idle_cycles(10);
        chk("latency", rise_cyc - t0, LAT);
        chk("a5_q_empty", exp_q.size(), 0);
        chk("a5_valid_cycles", n_vcyc, 1);
        chk("a5_frm", n_frm, 0);

        // back-to-back with consumer stalled: overrun, first word held
        i_ready = 1'b0; n_ovr = 0;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, 0);
        send_frame(8'hC3, 1'b1, 1'b0, 0);
        idle_cycles(10);
        chk("ovr_count", n_ovr, 1);
        chk("held_valid", {31'b0, o_valid}, 32'd1);
        chk("held_data", {24'b0, o_data}, 32'h3C);
        @(posedge clk); #2;
        i_ready = 1'b1;
        @(posedge clk); #2;
        chk("drop_after_accept", {31'b0, o_valid}, 32'd0);
        idle_cycles(10);
        chk("3c_q_empty", exp_q.size(), 0);
        chk("ovr_final", n_ovr, 1);

        // framing error, break, recovery
        n_frm = 0; n_vcyc = 0;
        send_frame(8'h55, 1'b0, 1'b0, 0);
        repeat (20) begin @(posedge clk); #2; i = 1'b0; end
        idle_cycles(10);
        chk("frm_count", n_frm, 1);
        chk("frm_no_valid", n_vcyc, 0);
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b1, 1'b0, 0);
        idle_cycles(10);
        chk("01_q_empty", exp_q.size(), 0);
        chk("frm_after_01", n_frm, 1);

        // 1-cycle glitch is ignored
        n_vcyc = 0; n_frm = 0;
        @(posedge clk); #2; i = 1'b0;
        @(posedge clk); #2; i = 1'b1;
        idle_cycles(20);
        chk("glitch_valid", n_vcyc, 0);
        chk("glitch_frm", n_frm, 0);

        // reset mid-data aborts silently
        send_frame(8'h96, 1'b1, 1'b0, 20);
        @(posedge clk); #2;
        i = 1'b1; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("midrst_valid", {31'b0, o_valid}, 32'd0);
        chk("midrst_frm", {31'b0, o_frm_err}, 32'd0);
        rst_n = 1'b1;
        n_vcyc = 0; n_frm = 0;
        idle_cycles(5);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0, 0);
        idle_cycles(10);
        chk("5a_q_empty", exp_q.size(), 0);
        chk("5a_valid_cycles", n_vcyc, 1);
        chk("5a_frm", n_frm, 0);

`ifdef BIT_SERIAL_RX_PARITY_EN
        n_frm = 0;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b0, 0);
        idle_cycles(10);
        chk("par_good_q_empty", exp_q.size(), 0);
        chk("par_good_frm", n_frm, 0);
        n_vcyc = 0;
        send_frame(8'h07, 1'b1, 1'b1, 0);
        idle_cycles(10);
        chk("par_bad_frm", n_frm, 1);
        chk("par_bad_valid", n_vcyc, 0);
`endif

        chk("final_q_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
